refrescamiento_display: RTL and testbench

//  Refresh scanner for the 4-digit 7-segment display. It sits directly upstream of the

---
 rtl/disp_pkg.sv | 25 ++
 rtl/prescaler_tick.sv | 28 ++
 rtl/refrescamiento_display.sv | 88 ++++++++
 tb/tb_refrescamiento_display.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the 4-digit 7-segment refresh scanner.
// Pure declarations; no timing or flow-control behaviour of its own.
package disp_pkg;

  typedef logic [1:0] sel_t;
  typedef logic [3:0] bcd_t;

  localparam int MAX_DIGITOS = 4;

  // Out-of-range digit counts clamp: 0 shows one digit, anything above 4 shows all four.
  function automatic logic [2:0] sat_digitos(input logic [2:0] n);
    if (n == 3'd0) begin
      return 3'd1;
    end else if (n > 3'(MAX_DIGITOS)) begin
      return 3'(MAX_DIGITOS);
    end else begin
      return n;
    end
  endfunction

  function automatic bcd_t nibble(input logic [15:0] v, input sel_t s);
    return v[{s, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Free-running divide-by-DIV counter; tick is high during the last count (combinational, 0-cycle).
// en=0 freezes the count so a paused scan resumes exactly where it stopped.
module prescaler_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/refrescamiento_display.sv
// Digit refresh scanner: steps the select once per tick, presents the frame-latched BCD nibble.
// Select, digito and frame_start are registered together; en=0 pauses everything and blanks.
module refrescamiento_display
  import disp_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1_000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [2:0]  num_digitos,
  input  logic [15:0] valor,
  output logic [1:0]  refrescamiento,
  output logic [3:0]  digito,
  output logic        blank,
  output logic        frame_start
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int BW  = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_ONE  = BW'(1);

  logic          tick;
  sel_t          sel;
  sel_t          last_sel;
  sel_t          sel_nxt;
  logic          wrap;
  bcd_t          dig;
  logic          fs;
  logic [15:0]   snap;
  logic [2:0]    act;
  logic [BW-1:0] bcnt;

  prescaler_tick #(
    .DIV(DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick)
  );

  assign last_sel = sel_t'(act - 3'd1);
  assign wrap     = (sel == last_sel);
  assign sel_nxt  = wrap ? sel_t'(0) : sel + sel_t'(1);

  // The nibble is chosen from the value the select is about to take, so both update on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel  <= '0;
      dig  <= '0;
      fs   <= 1'b0;
      snap <= '0;
      act  <= 3'(MAX_DIGITOS);
    end else begin
      fs <= tick && wrap;
      if (tick) begin
        sel <= sel_nxt;
        if (wrap) begin
          snap <= valor;
          act  <= sat_digitos(num_digitos);
          dig  <= nibble(valor, sel_t'(0));
        end else begin
          dig  <= nibble(snap, sel_nxt);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= BLANK_LOAD;
    end else if (tick) begin
      bcnt <= BLANK_LOAD;
    end else if (en && (bcnt != '0)) begin
      bcnt <= bcnt - BLANK_ONE;
    end
  end

  assign refrescamiento = sel;
  assign digito         = dig;
  assign frame_start    = fs;
  assign blank          = !rst_n || !en || (bcnt != '0);

endmodule

// File: tb/tb_refrescamiento_display.sv
// Directed bench for refrescamiento_display with DIV=10, BLANK_CYCLES=2.
module tb_refrescamiento_display;

  typedef struct {
    logic [2:0]  num;
    logic [15:0] valor;
    logic [1:0]  sel;
    logic [3:0]  dig;
    logic        fs;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  num_digitos;
  logic [15:0] valor;
  logic [1:0]  refrescamiento;
  logic [3:0]  digito;
  logic        blank;
  logic        frame_start;

  int   errors;
  int   checks;
  vec_t vq[$];

  refrescamiento_display #(
    .CLK_HZ      (1000),
    .REFRESH_HZ  (100),
    .BLANK_CYCLES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .num_digitos   (num_digitos),
    .valor         (valor),
    .refrescamiento(refrescamiento),
    .digito        (digito),
    .blank         (blank),
    .frame_start   (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] n, input logic [15:0] v, input logic [1:0] s,
                     input logic [3:0] d, input logic f);
    vec_t r;
    r.num = n; r.valor = v; r.sel = s; r.dig = d; r.fs = f;
    vq.push_back(r);
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [1:0] prev_sel;
    logic       ok;
    errors = 0;
    checks = 0;

    // {num_digitos, valor} driven during the tick period, then select/digit/frame_start after the tick
    add(3'd4, 16'h4321, 2'd1, 4'd0, 1'b0);
    add(3'd4, 16'h4321, 2'd2, 4'd0, 1'b0);
    add(3'd4, 16'h4321, 2'd3, 4'd0, 1'b0);
    add(3'd4, 16'h4321, 2'd0, 4'd1, 1'b1);
    add(3'd4, 16'h4321, 2'd1, 4'd2, 1'b0);
    add(3'd4, 16'h4321, 2'd2, 4'd3, 1'b0);
    add(3'd4, 16'h4321, 2'd3, 4'd4, 1'b0);
    add(3'd4, 16'h4321, 2'd0, 4'd1, 1'b1);
    add(3'd2, 16'h9999, 2'd1, 4'd2, 1'b0);
    add(3'd2, 16'h9999, 2'd2, 4'd3, 1'b0);
    add(3'd2, 16'h9999, 2'd3, 4'd4, 1'b0);
    add(3'd2, 16'h9999, 2'd0, 4'd9, 1'b1);
    add(3'd2, 16'h9999, 2'd1, 4'd9, 1'b0);
    add(3'd2, 16'h9999, 2'd0, 4'd9, 1'b1);
    add(3'd0, 16'h0005, 2'd1, 4'd9, 1'b0);
    add(3'd0, 16'h0005, 2'd0, 4'd5, 1'b1);
    add(3'd0, 16'h0005, 2'd0, 4'd5, 1'b1);
    add(3'd7, 16'h8761, 2'd0, 4'd1, 1'b1);
    add(3'd7, 16'h8761, 2'd1, 4'd6, 1'b0);
    add(3'd7, 16'h8761, 2'd2, 4'd7, 1'b0);
    add(3'd7, 16'h8761, 2'd3, 4'd8, 1'b0);
    add(3'd7, 16'h8761, 2'd0, 4'd1, 1'b1);

    rst_n       = 1'b0;
    en          = 1'b1;
    num_digitos = 3'd4;
    valor       = 16'h4321;
    edges(3);
    chk("reset_sel",   {14'd0, refrescamiento}, 16'd0);
    chk("reset_dig",   {12'd0, digito}, 16'd0);
    chk("reset_blank", {15'd0, blank}, 16'd1);
    chk("reset_fs",    {15'd0, frame_start}, 16'd0);
    rst_n = 1'b1;

    prev_sel = 2'd0;
    foreach (vq[i]) begin
      num_digitos = vq[i].num;
      valor       = vq[i].valor;
      edges(1);
      chk($sformatf("v%0d_blank_e1", i), {15'd0, blank}, 16'd1);
      chk($sformatf("v%0d_fs_e1", i),    {15'd0, frame_start}, 16'd0);
      edges(1);
      chk($sformatf("v%0d_blank_e2", i), {15'd0, blank}, 16'd0);
      edges(7);
      chk($sformatf("v%0d_sel_hold", i), {14'd0, refrescamiento}, {14'd0, prev_sel});
      chk($sformatf("v%0d_blank_e9", i), {15'd0, blank}, 16'd0);
      edges(1);
      chk($sformatf("v%0d_sel", i),      {14'd0, refrescamiento}, {14'd0, vq[i].sel});
      chk($sformatf("v%0d_dig", i),      {12'd0, digito}, {12'd0, vq[i].dig});
      chk($sformatf("v%0d_fs", i),       {15'd0, frame_start}, {15'd0, vq[i].fs});
      chk($sformatf("v%0d_blank_tick", i), {15'd0, blank}, 16'd1);
      prev_sel = vq[i].sel;
    end

    // Pause at prescaler=5: held select, forced blank, then the tick arrives 5 clocks after resume.
    edges(5);
    en = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 25; k++) begin
      edges(1);
      if (refrescamiento !== 2'd0 || blank !== 1'b1 || frame_start !== 1'b0) ok = 1'b0;
    end
    chk("pause_hold", {15'd0, ok}, 16'd1);
    en = 1'b1;
    edges(4);
    chk("resume_sel_e4",   {14'd0, refrescamiento}, 16'd0);
    chk("resume_blank_e4", {15'd0, blank}, 16'd0);
    edges(1);
    chk("resume_sel_e5",   {14'd0, refrescamiento}, 16'd1);
    chk("resume_dig_e5",   {12'd0, digito}, 16'd6);
    chk("resume_blank_e5", {15'd0, blank}, 16'd1);

    // Asynchronous reset between edges, mid-frame.
    edges(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel",   {14'd0, refrescamiento}, 16'd0);
    chk("arst_dig",   {12'd0, digito}, 16'd0);
    chk("arst_blank", {15'd0, blank}, 16'd1);
    chk("arst_fs",    {15'd0, frame_start}, 16'd0);
    edges(2);
    rst_n = 1'b1;
    edges(9);
    chk("post_rst_sel_e9", {14'd0, refrescamiento}, 16'd0);
    edges(1);
    chk("post_rst_sel_e10", {14'd0, refrescamiento}, 16'd1);
    chk("post_rst_dig_e10", {12'd0, digito}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
